// File: rtl/housekeeping_spi_gen.sv
// -----------------------------------------------------------------------------
// housekeeping_spi_gen
//
// Parametrised SPI slave for the housekeeping register file. It decodes an
// 8-bit command, an ADDR_W-bit address and DATA_W-bit data words from SCK/SDI.
// It presents them upstream as a parallel address/data bus with one-SCK
// read/write strobes. It can also hand the SPI pins to one of NPASS flash
// pass-through channels.
//
// Ports:
//   SCK             SPI clock; SDI sampled on rising edge, SDO driven on falling
//   csb_reset       CSB OR system reset, asynchronous, active high
//   SDI / SDO       serial data in / out, msb first
//   sdoenb          SDO output enable, active low
//   idata           readback data for the current oaddr
//   odata / oaddr   write data / register address to upstream
//   rdstb / wrstb   read / write strobes, one SCK period each
//   pass_thru       channel k owns the SPI pins
//   pass_thru_delay channel k selected, one SCK ahead of pass_thru
//   pass_thru_reset pass_thru_delay & ~pass_thru
//
// Optional feature macro: HKSPI_ADDR_WRAP_EN
//   defined   : the address increment wraps from all-ones to zero and the
//               transfer continues
//   undefined : an increment from all-ones parks the slave in DONE with the
//               address held at max
// -----------------------------------------------------------------------------
module housekeeping_spi_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NPASS  = 2
) (
  input  logic              SCK,
  input  logic              csb_reset,
  input  logic              SDI,
  output logic              SDO,
  output logic              sdoenb,
  input  logic [DATA_W-1:0] idata,
  output logic [DATA_W-1:0] odata,
  output logic [ADDR_W-1:0] oaddr,
  output logic              rdstb,
  output logic              wrstb,
  output logic [NPASS-1:0]  pass_thru,
  output logic [NPASS-1:0]  pass_thru_delay,
  output logic [NPASS-1:0]  pass_thru_reset
);

  typedef enum logic [2:0] {CMD, ADDR, DATA, PASS, DONE} state_t;

  // Wide enough for the longest phase (32 data bits).
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [6:0]        cmd_bits;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-2:0] predata;
  logic [DATA_W-1:0] ldata;
  logic              readmode;
  logic              writemode;
  logic [2:0]        fixed;
  logic [2:0]        cmd_sel;
  logic [NPASS-1:0]  sel_onehot;

  // The select field is complete only on the 8th command edge, when its
  // last bit is still on SDI.
  assign cmd_sel = {cmd_bits[1:0], SDI};

  // One-hot channel decode; sel=0 and sel>NPASS both decode to all zeros,
  // which sends the command on to the address phase.
  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < NPASS; k++) begin
      if (cmd_sel == 3'(k + 1)) sel_onehot[k] = 1'b1;
    end
  end

  // The upstream bus sees the address/data including the bit currently on
  // SDI, so it can latch complete words on the final rising edge.
  assign oaddr = (state == ADDR) ? {addr[ADDR_W-2:0], SDI} : addr;
  assign odata = {predata, SDI};
  assign SDO   = ldata[DATA_W-1];
  assign pass_thru_reset = pass_thru_delay & ~pass_thru;

  // Rising-edge phase sequencer: shifts in command/address/data and issues
  // the read strobe. rdstb defaults low so it lasts exactly one SCK.
  always_ff @(posedge SCK or posedge csb_reset) begin
    if (csb_reset) begin
      state           <= CMD;
      count           <= '0;
      cmd_bits        <= '0;
      addr            <= '0;
      predata         <= '0;
      readmode        <= 1'b0;
      writemode       <= 1'b0;
      fixed           <= 3'd0;
      rdstb           <= 1'b0;
      pass_thru       <= '0;
      pass_thru_delay <= '0;
    end else begin
      rdstb <= 1'b0;
      case (state)
        CMD: begin
          cmd_bits <= {cmd_bits[5:0], SDI};
          if (count == CMD_LAST) begin
            count     <= '0;
            writemode <= cmd_bits[6];
            readmode  <= cmd_bits[5];
            fixed     <= cmd_bits[4:2];
            if (|sel_onehot) begin
              state           <= PASS;
              pass_thru_delay <= sel_onehot;
            end else begin
              state <= ADDR;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        ADDR: begin
          addr <= {addr[ADDR_W-2:0], SDI};
          if (count == ADDR_LAST) begin
            count <= '0;
            state <= DATA;
            rdstb <= readmode;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DATA: begin
          predata <= {predata[DATA_W-3:0], SDI};
          if (count == DATA_LAST) begin
            count <= '0;
            if (fixed == 3'd1) begin
              // Last word of a fixed-length transfer.
              state <= CMD;
              rdstb <= readmode;
            end else begin
              if (fixed != 3'd0) fixed <= fixed - 3'd1;
              if (addr == ADDR_MAX) begin
`ifdef HKSPI_ADDR_WRAP_EN
                addr  <= '0;
                rdstb <= readmode;
`else
                // Address space exhausted: stop strobing until CSB rises.
                state <= DONE;
`endif
              end else begin
                addr  <= addr + ADDR_W'(1);
                rdstb <= readmode;
              end
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        PASS: begin
          pass_thru <= pass_thru_delay;
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= CMD;
        end
      endcase
    end
  end

  // Falling-edge output side: drives SDO/sdoenb half a cycle ahead of the
  // master's sampling edge and raises wrstb before the final data edge.
  // ldata is zeroed whenever not reading so SDO idles low.
  always_ff @(negedge SCK or posedge csb_reset) begin
    if (csb_reset) begin
      sdoenb <= 1'b1;
      ldata  <= '0;
      wrstb  <= 1'b0;
    end else begin
      wrstb <= (state == DATA) && writemode && (count == DATA_LAST);
      if ((state == DATA) && readmode) begin
        sdoenb <= 1'b0;
        if (count == '0) ldata <= idata;
        else             ldata <= {ldata[DATA_W-2:0], 1'b0};
      end else if ((state == PASS) && (|pass_thru)) begin
        sdoenb <= 1'b0;
        ldata  <= '0;
      end else begin
        sdoenb <= 1'b1;
        ldata  <= '0;
      end
    end
  end

endmodule
